// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle 16-bit multiply/divide unit for the mips16 core.
// Runs an iterative shift-add multiply or a restoring divide over WIDTH cycles,
// holds the core with instr_stall_sl while busy, pulses ready when HI/LO update.
// Optional feature: define SIGNED_MULDIV_EN to add the signed_op port and
// signed multiply/divide (magnitude iteration plus sign fix-up on completion).
module mult_div_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
`ifdef SIGNED_MULDIV_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_lo_sl,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             instr_stall_sl,
    output logic             ready,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_acc: multiply accumulator upper half / divide partial remainder
    // r_low: multiplier being shifted out / quotient being shifted in
    // r_opb: multiplicand / divisor
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_low;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;
    logic               r_ready;
    logic               r_neg_res;
    logic               r_neg_rem;

    logic               w_sgn;
    logic               w_accept;
    logic               w_last;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH-1:0]   w_mul_low;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

`ifdef SIGNED_MULDIV_EN
    assign w_sgn = signed_op;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));
    assign w_div_zero = (operand_b == '0);

    // Signed operands iterate as magnitudes; the most negative value still fits unsigned.
    assign w_a_mag = (w_sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign w_b_mag = (w_sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Multiply step: conditional add into the upper half with carry, then shift right.
    assign w_sum      = {1'b0, r_acc} + {1'b0, (r_low[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_acc  = w_sum[WIDTH:1];
    assign w_mul_low  = {w_sum[0], r_low[WIDTH-1:1]};
    assign w_prod     = {w_mul_acc, w_mul_low};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    // The difference only matters when it is non-negative, where it fits WIDTH bits.
    assign w_shift   = {r_acc, r_low[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opb});
    assign w_diff    = w_shift[WIDTH-1:0] - r_opb;
    assign w_div_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_quo = {r_low[WIDTH-2:0], w_ge};
    assign w_quo_fix = r_neg_res ? -w_div_quo : w_div_quo;
    assign w_rem_fix = r_neg_rem ? -w_div_rem : w_div_rem;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and stall request.
    always_comb begin
        w_state_next   = r_state;
        instr_stall_sl = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                instr_stall_sl = start;
                if (start) begin
                    if (!op_div) begin
                        w_state_next = S_MULT;
                    end else if (w_div_zero) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_DIV;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MULT: begin
                instr_stall_sl = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                instr_stall_sl = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, one iteration per busy cycle, HI/LO write on completion.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_low     <= '0;
            r_opb     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz     <= 1'b0;
            r_ready   <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            r_ready <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_count   <= '0;
                r_dbz     <= 1'b0;
                r_acc     <= '0;
                r_neg_res <= w_sgn && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                r_neg_rem <= w_sgn && operand_a[WIDTH-1];
                if (op_div && w_div_zero) begin
                    r_hi  <= operand_a;
                    r_lo  <= '1;
                    r_dbz <= 1'b1;
                end else if (op_div) begin
                    r_low <= w_a_mag;
                    r_opb <= w_b_mag;
                end else begin
                    r_low <= w_b_mag;
                    r_opb <= w_a_mag;
                end
            end else if (r_state == S_MULT) begin
                r_acc   <= w_mul_acc;
                r_low   <= w_mul_low;
                r_count <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end else if (r_state == S_DIV) begin
                r_acc   <= w_div_rem;
                r_low   <= w_div_quo;
                r_count <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign ready       = r_ready;
    assign div_by_zero = r_dbz;
    assign result      = hi_lo_sl ? r_hi : r_lo;

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multi-cycle multiply/divide unit with its controller, serving the single-cycle mips16 core.
- Runs 16-bit iterative shift-add multiply and restoring divide, and writes the HI/LO result registers.
- Asserts instr_stall_sl to freeze PC and instruction fetch while an operation is in flight, then pulses ready.
- Drives the HI/LO read path selected by hi_lo_sl for mfhi/mflo.

Parameters:
- WIDTH, 16, operand and HI/LO register width.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- start  input  1  decoded mult/div instruction present this cycle.
- op_div  input  1  0 = multiply, 1 = divide; sampled with start.
- operand_a  input  WIDTH  multiplicand or dividend (rs).
- operand_b  input  WIDTH  multiplier or divisor (rt).
- hi_lo_sl  input  1  read select: 1 = HI, 0 = LO.
- result  output  WIDTH  combinational mux of hi/lo per hi_lo_sl.
- hi  output  WIDTH  HI register: product[31:16] or remainder.
- lo  output  WIDTH  LO register: product[15:0] or quotient.
- instr_stall_sl  output  1  stall request to the PC/fetch path.
- ready  output  1  one-cycle pulse; new hi/lo valid this cycle.
- div_by_zero  output  1  sticky flag for the last divide; cleared by the next accepted start.

Behaviour:
- Reset: reset_n low at a rising edge forces state IDLE, hi=0, lo=0, counter=0, div_by_zero=0. ready=0 and instr_stall_sl=0 the following cycle. Reset mid-operation abandons the operation with no partial hi/lo write.
- States: IDLE, MULT, DIV, DONE. DONE lasts exactly one cycle.
- Accept: start is accepted in IDLE or DONE. On the accepting edge:
  - latch operands;
  - clear counter;
  - clear div_by_zero;
  - go to MULT (op_div=0) or DIV (op_div=1).
- Ignore: start is ignored in MULT and DIV.
- Divide-by-zero: op_div=1 with operand_b=0 goes directly to DONE and writes lo={WIDTH{1}}, hi=operand_a, div_by_zero=1.
- MULT, each cycle:
  - if the multiplier LSB is 1, add the multiplicand to the upper accumulator half (WIDTH+1 bits to keep the carry);
  - shift {carry, acc, multiplier} right 1;
  - counter += 1.
- DIV, each cycle:
  - shift {rem, quotient} left 1;
  - trial = rem - divisor;
  - if not negative, rem = trial and quotient LSB = 1;
  - counter += 1.
- Completion: when counter reaches WIDTH-1 in MULT/DIV, the next edge writes hi/lo and enters DONE.
- instr_stall_sl, combinational: (state∈{IDLE,DONE} && start) || state∈{MULT,DIV}.
- ready, registered: 1 only in DONE. instr_stall_sl in DONE depends only on start.
- Latency: start accepted at cycle T gives stall during T..T+16, hi/lo updated and ready=1 at T+17. Divide-by-zero gives stall at T, ready at T+1.
- Back-to-back: start in DONE is accepted. ready still pulses for the completed op, and the stall for the new op is asserted in the same cycle.
- hi/lo hold their value from completion until the next completion or reset. result tracks hi_lo_sl combinationally.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- With the macro defined, a port signed_op (input, 1) is sampled with start. When signed_op=1:
  - operands are converted to magnitudes before iteration;
  - product and quotient are negated if the signs differ;
  - the remainder takes the dividend's sign.
  - Latency is unchanged; sign fix-up is applied on the write into DONE.
- Without the macro, there is no signed_op port and all operations are unsigned.

Test Plan:
- Multiply: reset_n=0 for 2 cycles, then start, op_div=0, a=300, b=500. Required: stall for 17 cycles; ready at T+17; hi=0x0002, lo=0x49F0; result=0x0002 with hi_lo_sl=1.
- Divide: start, op_div=1, a=1000, b=7. Required: ready at T+17; lo=0x008E, hi=0x0006; div_by_zero=0.
- Divide by zero: start, op_div=1, a=0x04D2, b=0. Required: stall only at T; ready at T+1; lo=0xFFFF, hi=0x04D2, div_by_zero=1. A following multiply clears the flag.
- Busy and back-to-back:
  - start pulses during MULT are ignored and the result is unchanged;
  - start held in the DONE cycle launches a second op, with ready and stall both 1 that cycle;
  - reset_n=0 at T+8 gives IDLE, hi=lo=0, no ready.
- Signed (SIGNED_MULDIV_EN):
  - signed 0xFFFD×5 gives hi=0xFFFF, lo=0xFFF1;
  - signed -7÷2 gives lo=0xFFFD, hi=0xFFFF.
- Unsigned build: 0xFFFD×5 gives hi=0x0004, lo=0xFFF1.
